// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between an instruction-fetch
// requester and a data requester. One transaction is outstanding at a time.
// Data normally wins, but a fetch that has waited through STARVE_LIMIT
// consecutive data grants is served next. A busy period with no mem_ready
// for TIMEOUT cycles is aborted with zero read data and a sticky err flag.
//
// Ports
//   clk, rst_n          : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   if_req/if_addr      : fetch request and address
//   if_stall/if_valid   : fetch waiting / fetch completes this cycle (comb)
//   if_rdata            : fetched word, zero unless a real completion (comb)
//   d_req/d_we/d_addr/d_wdata : data request, write enable, address, write data
//   d_stall/d_valid     : data waiting / data completes this cycle (comb)
//   d_rdata             : load result, zero unless a real completion (comb)
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request
//   mem_ready/mem_rdata : memory completion and read data
//   err                 : sticky timeout flag, cleared only by reset
module mem_arbiter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_stall,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_rdata,

    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_stall,
    output logic             d_valid,
    output logic [WIDTH-1:0] d_rdata,

    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,

    output logic             err
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned BW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
    logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
    logic             err_q, err_d;
    logic             mem_req_q, mem_req_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             timeout_hit;
    logic             starved;

    // A pending fetch that has already lost STARVE_LIMIT grants in a row.
    assign starved = if_req && (starve_cnt_q == SW'(STARVE_LIMIT));

    // Next-state, grant, latch and timeout logic.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        busy_cnt_d   = busy_cnt_q;
        err_d        = err_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        timeout_hit  = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ready is ignored here.
                if (d_req && !starved) begin
                    state_d    = D_BUSY;
                    addr_d     = d_addr;
                    we_d       = d_we;
                    wdata_d    = d_wdata;
                    busy_cnt_d = '0;
                    // Counter is below the limit whenever data wins with
                    // if_req high, so the increment cannot overflow.
                    starve_cnt_d = if_req ? starve_cnt_q + SW'(1) : '0;
                end else if (if_req) begin
                    state_d      = IF_BUSY;
                    addr_d       = if_addr;
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    busy_cnt_d   = '0;
                    starve_cnt_d = '0;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end else if (busy_cnt_q == BW'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_req_d = (state_d != IDLE);
    end

    // State and datapath registers; reset also discards any in-flight access.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            busy_cnt_q   <= '0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            busy_cnt_q   <= busy_cnt_d;
            err_q        <= err_d;
            mem_req_q    <= mem_req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Completion pulses; suppressed while reset is asserted so an aborted
    // transaction never reports a result.
    assign if_valid = !rst_n && (state_q == IF_BUSY) && (mem_ready || timeout_hit);
    assign d_valid  = !rst_n && (state_q == D_BUSY)  && (mem_ready || timeout_hit);

    // Read data is zeroed on a timeout completion.
    assign if_rdata = (if_valid && !timeout_hit) ? mem_rdata : '0;
    assign d_rdata  = (d_valid  && !timeout_hit) ? mem_rdata : '0;

    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req  && !d_valid;

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 time unit after the rising
// edge, outputs are sampled at the falling edge.
module tb_mem_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_stall;
    logic             if_valid;
    logic [WIDTH-1:0] if_rdata;
    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_stall;
    logic             d_valid;
    logic [WIDTH-1:0] d_rdata;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;
    logic             err;

    int checks;
    int failures;

    mem_arbiter #(
        .WIDTH        (WIDTH),
        .STARVE_LIMIT (4),
        .TIMEOUT      (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_stall  (if_stall),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_stall   (d_stall),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    initial begin
        int unsigned grant_addr [10];
        int unsigned exp_addr   [10];
        int          ngrant;
        int          nwait;
        logic        found;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Reset state.
        tick;
        tick;
        settle;
        check("rst_mem_req",   32'(mem_req),  32'd0);
        check("rst_mem_we",    32'(mem_we),   32'd0);
        check("rst_mem_addr",  mem_addr,      32'd0);
        check("rst_mem_wdata", mem_wdata,     32'd0);
        check("rst_err",       32'(err),      32'd0);
        check("rst_valids",    32'({if_valid, d_valid}), 32'd0);
        tick;
        rst_n = 1'b0;

        // Single fetch, memory answers in the first busy cycle.
        tick;
        if_req  = 1'b1;
        if_addr = 32'h10;
        settle;
        check("if_req_mem_req_t0", 32'(mem_req),  32'd0);
        check("if_stall_t0",       32'(if_stall), 32'd1);
        tick;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE0001;
        settle;
        check("if_mem_req_t1",  32'(mem_req),  32'd1);
        check("if_mem_addr_t1", mem_addr,      32'h10);
        check("if_mem_we_t1",   32'(mem_we),   32'd0);
        check("if_valid_t1",    32'(if_valid), 32'd1);
        check("if_rdata_t1",    if_rdata,      32'hCAFE0001);
        check("if_stall_t1",    32'(if_stall), 32'd0);
        check("if_no_dvalid",   32'(d_valid),  32'd0);
        tick;
        if_req = 1'b0;
        settle;
        check("if_mem_req_t2",  32'(mem_req),  32'd0);
        check("if_valid_t2",    32'(if_valid), 32'd0);

        // mem_ready while idle is ignored.
        mem_rdata = 32'h1234;
        tick;
        settle;
        check("idle_rdy_valids",  32'({if_valid, d_valid}), 32'd0);
        check("idle_rdy_rdata",   if_rdata | d_rdata,       32'd0);
        tick;
        settle;
        check("idle_rdy_mem_req", 32'(mem_req), 32'd0);
        check("idle_rdy_addr",    mem_addr,     32'h10);
        mem_ready = 1'b0;

        // Data write held stable until mem_ready.
        tick;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'hDEADBEEF;
        settle;
        check("wr_stall_t0", 32'(d_stall), 32'd1);
        tick;
        d_addr  = 32'h99;
        d_wdata = 32'h0;
        d_we    = 1'b0;
        settle;
        check("wr_mem_req",   32'(mem_req), 32'd1);
        check("wr_mem_we",    32'(mem_we),  32'd1);
        check("wr_mem_addr",  mem_addr,     32'h40);
        check("wr_mem_wdata", mem_wdata,    32'hDEADBEEF);
        check("wr_valid_t1",  32'(d_valid), 32'd0);
        check("wr_stall_t1",  32'(d_stall), 32'd1);
        tick;
        settle;
        check("wr_hold_wdata", mem_wdata,    32'hDEADBEEF);
        check("wr_hold_we",    32'(mem_we),  32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h55;
        #1;
        check("wr_valid",     32'(d_valid), 32'd1);
        check("wr_stall_end", 32'(d_stall), 32'd0);
        d_req = 1'b0;
        tick;
        mem_ready = 1'b0;
        settle;
        check("wr_valid_once", 32'(d_valid), 32'd0);
        check("wr_mem_req_off", 32'(mem_req), 32'd0);

        // Both requesters continuously active: fetch wins every fifth grant.
        tick;
        if_req    = 1'b1;
        if_addr   = 32'h100;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h200;
        mem_ready = 1'b1;
        mem_rdata = 32'h77;
        exp_addr  = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100,
                      32'h200, 32'h200, 32'h200, 32'h200, 32'h100};
        ngrant    = 0;
        for (int i = 0; i < 40 && ngrant < 10; i++) begin
            tick;
            settle;
            if (if_valid || d_valid) begin
                grant_addr[ngrant] = mem_addr;
                ngrant++;
                if (ngrant == 10) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
        end
        check("starve_grant_count", 32'(ngrant), 32'd10);
        for (int i = 0; i < ngrant; i++) begin
            check($sformatf("starve_grant_%0d", i), grant_addr[i], exp_addr[i]);
        end
        tick;
        mem_ready = 1'b0;

        // Data read that never sees mem_ready times out.
        tick;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h80;
        mem_rdata = 32'hFFFFFFFF;
        nwait     = 0;
        found     = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick;
            settle;
            if (d_valid) found = 1'b1;
            else         nwait++;
        end
        check("to_found",       32'(found),   32'd1);
        check("to_wait_cycles", 32'(nwait),   32'd255);
        check("to_rdata",       d_rdata,      32'd0);
        check("to_err_before",  32'(err),     32'd0);
        d_req = 1'b0;
        tick;
        settle;
        check("to_err_set",   32'(err),     32'd1);
        check("to_mem_req",   32'(mem_req), 32'd0);
        check("to_no_valid",  32'(d_valid), 32'd0);
        tick;
        tick;
        settle;
        check("to_err_sticky", 32'(err), 32'd1);

        // Reset during a data access aborts it; the pending request is regranted.
        d_req  = 1'b1;
        d_addr = 32'hA0;
        tick;
        settle;
        check("rb_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b1;
        tick;
        settle;
        check("rb_mem_req_off", 32'(mem_req), 32'd0);
        check("rb_no_valid",    32'(d_valid), 32'd0);
        check("rb_err_clear",   32'(err),     32'd0);
        check("rb_addr_clear",  mem_addr,     32'd0);
        rst_n = 1'b0;
        tick;
        mem_ready = 1'b1;
        mem_rdata = 32'h1234ABCD;
        settle;
        check("rb_regrant",   32'(mem_req), 32'd1);
        check("rb_addr",      mem_addr,     32'hA0);
        check("rb_valid",     32'(d_valid), 32'd1);
        check("rb_rdata",     d_rdata,      32'h1234ABCD);
        d_req = 1'b0;
        tick;
        mem_ready = 1'b0;
        settle;
        check("rb_idle", 32'(mem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive data grants allowed while a fetch is pending.
REQ-003 Parameter TIMEOUT, default 255, busy cycles without mem_ready before abort.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-high reset (1 = reset, sampled on clk edge).
REQ-006 if_req  in  1  fetch request; if_addr  in  WIDTH  fetch address.
REQ-007 if_stall  out  1  fetch not yet served; if_valid  out  1  fetch completes this cycle; if_rdata  out  WIDTH  fetched word.
REQ-008 d_req  in  1  data request; d_we  in  1  write when 1; d_addr  in  WIDTH; d_wdata  in  WIDTH.
REQ-009 d_stall  out  1  data access not yet served; d_valid  out  1  data access completes this cycle; d_rdata  out  WIDTH  load result.
REQ-010 mem_req  out  1; mem_we  out  1; mem_addr  out  WIDTH; mem_wdata  out  WIDTH  shared port to external memory.
REQ-011 mem_ready  in  1  memory completes access this cycle; mem_rdata  in  WIDTH  read data, valid with mem_ready.
REQ-012 err  out  1  sticky timeout flag.

Function
REQ-013 FSM states: IDLE, IF_BUSY, D_BUSY; exactly one transaction outstanding at a time.
REQ-014 IDLE grant rule: d_req=1 and not (if_req=1 and starve_cnt==STARVE_LIMIT) -> D_BUSY; else if_req=1 -> IF_BUSY; else stay IDLE.
REQ-015 On grant, the winner's address (and for data, d_we/d_wdata) are latched into registers driving mem_addr/mem_we/mem_wdata; mem_we=0 for fetch.
REQ-016 mem_req=1 exactly while state is IF_BUSY or D_BUSY; registered, so request in IDLE at cycle t gives mem_req=1 at t+1.
REQ-017 mem_addr/mem_we/mem_wdata hold constant for the whole busy period regardless of requester inputs.
REQ-018 In a busy state with mem_ready=1: completion; next state IDLE; new grant earliest the following cycle (min latency request->valid = 2 cycles, throughput 1 access per 2 cycles).
REQ-019 if_valid = (state==IF_BUSY) & (mem_ready | timeout_hit); d_valid likewise for D_BUSY; combinational, one-cycle pulse.
REQ-020 if_rdata = mem_rdata when if_valid and not timeout, else 0; d_rdata same rule; d_rdata is don't-care-but-driven (mem_rdata) on writes.
REQ-021 if_stall = if_req & ~if_valid; d_stall = d_req & ~d_valid; combinational.
REQ-022 starve_cnt (width clog2(STARVE_LIMIT+1)): +1 on each data grant made while if_req=1; cleared on fetch grant or on data grant with if_req=0; saturates at STARVE_LIMIT.
REQ-023 Simultaneous if_req and d_req with starve_cnt<STARVE_LIMIT: data wins.
REQ-024 busy_cnt counts cycles in a busy state, cleared on entry; when busy_cnt==TIMEOUT with mem_ready=0: timeout_hit=1, completion per REQ-019 with rdata=0, err set, state -> IDLE.
REQ-025 Requester dropping its req mid-transaction does not abort it; the valid pulse still occurs and is ignored by the requester.
REQ-026 mem_ready while IDLE is ignored; no valid pulse, no state change.

Reset
REQ-027 rst_n=1 at an edge: state=IDLE, starve_cnt=0, busy_cnt=0, err=0, latched addr/we/wdata=0; hence mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=d_valid=0.
REQ-028 Reset mid-transaction aborts it: mem_req=0 from the next cycle, no valid pulse, in-flight result discarded.
REQ-029 err clears only by reset.

Verification
REQ-030 if_req=1, if_addr=0x10, mem_ready=1 one cycle after mem_req -> mem_req at t+1, mem_addr=0x10, mem_we=0, if_valid and if_rdata=mem_rdata at t+1, if_stall low at t+1.
REQ-031 d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF held until mem_ready; d_valid pulses once.
REQ-032 if_req and d_req held high continuously, mem_ready=1 every busy cycle -> grant order D,D,D,D,IF,D,D,D,D,IF (STARVE_LIMIT=4).
REQ-033 d_req=1, mem_ready held 0 -> after 255 busy cycles d_valid=1, d_rdata=0, err=1 sticky, mem_req=0 next cycle.
REQ-034 rst_n=1 during D_BUSY -> next cycle mem_req=0, state IDLE, no d_valid; d_req still high -> new grant after reset releases.
REQ-035 mem_ready=1 while IDLE, no requests -> no outputs change.
